// File: rtl/rvfi_pkg.sv
// rvfi_pkg
// Shared RVFI types for the commit serializer slice.
//   rvfi_instr_t     : one retired-instruction record as emitted by the core
//                      on a single commit port.
//   rvfi_seq_entry_t : a buffered record together with its 64-bit sequence
//                      number; this is the element type of the serializer FIFO.
//   is_record()      : a port carries a record when it retires or traps.
package rvfi_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic            valid;
    logic [63:0]     order;
    logic [ILEN-1:0] insn;
    logic            trap;
    logic [XLEN-1:0] cause;
    logic            halt;
    logic            intr;
    logic [1:0]      mode;
    logic [1:0]      ixl;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_rmask;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
  } rvfi_instr_t;

  typedef struct packed {
    rvfi_instr_t instr;
    logic [63:0] seq;
  } rvfi_seq_entry_t;

  function automatic logic is_record(input rvfi_instr_t r);
    return r.valid | r.trap;
  endfunction

endpackage

// File: rtl/rvfi_commit_compact.sv
// rvfi_commit_compact
// Purely combinational packer for one cycle's commit bundle. Ports that carry
// a record (valid or trap) are moved to the low slots in ascending port order,
// without gaps, and each packed slot k is tagged with base_seq + k.
// Ports:
//   rvfi     in  : commit bundle, port 0 oldest
//   base_seq in  : sequence number of the first record of this cycle
//   records  out : packed records, slots >= count are zero
//   seqs     out : sequence number of each packed slot
//   count    out : number of records found this cycle
module rvfi_commit_compact
  import rvfi_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int SEQ_W           = 64
) (
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]            rvfi,
  input  logic [SEQ_W-1:0]                             base_seq,
  output rvfi_instr_t [NR_COMMIT_PORTS-1:0]            records,
  output logic [NR_COMMIT_PORTS-1:0][SEQ_W-1:0]        seqs,
  output logic [$clog2(NR_COMMIT_PORTS+1)-1:0]         count
);

  localparam int CNT_W = $clog2(NR_COMMIT_PORTS + 1);

  logic [CNT_W-1:0] idx;

  // idx is the next free packed slot; it only advances on a record, which is
  // what closes the gaps left by idle ports.
  always_comb begin
    records = '0;
    seqs    = '0;
    idx     = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (is_record(rvfi[i])) begin
        records[idx] = rvfi[i];
        seqs[idx]    = base_seq + SEQ_W'(idx);
        idx          = idx + CNT_W'(1);
      end
    end
    count = idx;
  end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// rvfi_commit_serializer
// Buffers up to NR_COMMIT_PORTS RVFI records per cycle into a DEPTH-entry FIFO
// and drains them one per cycle over a valid/ready handshake, in program
// order. Every record, kept or dropped, consumes one sequence number so the
// consumer can see losses as gaps in seq_o.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   rvfi_i       : commit bundle, port 0 oldest
//   rvfi_o/seq_o : head record and its sequence number (zero when empty)
//   out_valid_o  : head present
//   out_ready_i  : consumer takes the head this cycle
//   level_o      : FIFO occupancy, 0..DEPTH
//   overflow_o   : sticky, a record has been dropped since reset
//   drop_cnt_o   : saturating count of dropped records
// DEPTH must be a power of two >= 2 and >= NR_COMMIT_PORTS; SEQ_W <= 64.
module rvfi_commit_serializer
  import rvfi_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8,
  parameter int SEQ_W           = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_i,
  output rvfi_instr_t                         rvfi_o,
  output logic [SEQ_W-1:0]                    seq_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [$clog2(DEPTH):0]              level_o,
  output logic                                overflow_o,
  output logic [31:0]                         drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(NR_COMMIT_PORTS + 1);

  rvfi_seq_entry_t mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level;
  logic [SEQ_W-1:0] seq_cnt;
  logic [31:0]      drop_cnt;
  logic             overflow;

  rvfi_instr_t [NR_COMMIT_PORTS-1:0]     records;
  logic [NR_COMMIT_PORTS-1:0][SEQ_W-1:0] seqs;
  logic [CNT_W-1:0]                      rec_count;

  logic             pop;
  logic [LVL_W-1:0] free_slots;
  logic [LVL_W-1:0] rec_count_l;
  logic [LVL_W-1:0] accept;
  logic [LVL_W-1:0] dropped;
  logic [32:0]      drop_sum;
  logic [31:0]      drop_next;
  rvfi_seq_entry_t  head;

  rvfi_commit_compact #(
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .SEQ_W           (SEQ_W)
  ) u_compact (
    .rvfi     (rvfi_i),
    .base_seq (seq_cnt),
    .records  (records),
    .seqs     (seqs),
    .count    (rec_count)
  );

  // A slot vacated by this cycle's pop counts as free, so a full FIFO that is
  // being drained still takes one new record per cycle. Records beyond the
  // free space are dropped from the tail of the packed list, which keeps the
  // oldest ones.
  always_comb begin
    pop         = (level != '0) && out_ready_i;
    free_slots  = LVL_W'(DEPTH) - level + LVL_W'(pop);
    rec_count_l = LVL_W'(rec_count);
    accept      = (rec_count_l < free_slots) ? rec_count_l : free_slots;
    dropped     = rec_count_l - accept;
    drop_sum    = {1'b0, drop_cnt} + 33'(dropped);
    drop_next   = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  // Storage carries no reset: an entry is only ever observed through the
  // occupancy count, which does reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (LVL_W'(k) < accept) begin
        mem[wr_ptr + PTR_W'(k)] <= '{instr: records[k], seq: 64'(seqs[k])};
      end
    end
  end

  // Pointers, occupancy and counters. The sequence counter advances by the
  // full record count, dropped records included, so losses show as gaps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      seq_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      wr_ptr  <= wr_ptr + PTR_W'(accept);
      level   <= level - LVL_W'(pop) + accept;
      seq_cnt <= seq_cnt + SEQ_W'(rec_count);
      if (dropped != '0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_next;
      end
    end
  end

  // Head is taken straight from storage; empty forces zeros so stale entries
  // never leak out.
  always_comb begin
    head        = mem[rd_ptr];
    out_valid_o = (level != '0);
    rvfi_o      = out_valid_o ? head.instr : '0;
    seq_o       = out_valid_o ? head.seq[SEQ_W-1:0] : '0;
    level_o     = level;
    overflow_o  = overflow;
    drop_cnt_o  = drop_cnt;
  end

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// tb_rvfi_commit_serializer
// Self-checking bench for rvfi_commit_serializer with NR_COMMIT_PORTS=2,
// DEPTH=8, SEQ_W=64. A scoreboard queue models the FIFO contents: records
// the model accepts are pushed with their expected sequence number when the
// stimulus is applied, and popped when the modelled consumer takes the head.
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 8;
  localparam int SEQ_W = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  rvfi_instr_t [NR-1:0] rvfi_in;
  rvfi_instr_t          rvfi_out;
  logic [SEQ_W-1:0]     seq_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [$clog2(DEPTH):0] level;
  logic                 overflow;
  logic [31:0]          drop_cnt;

  always #5 clk = ~clk;

  rvfi_commit_serializer #(
    .NR_COMMIT_PORTS (NR),
    .DEPTH           (DEPTH),
    .SEQ_W           (SEQ_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rvfi_i      (rvfi_in),
    .rvfi_o      (rvfi_out),
    .seq_o       (seq_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .level_o     (level),
    .overflow_o  (overflow),
    .drop_cnt_o  (drop_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [63:0] seq;
    logic        trap;
    logic [31:0] cause;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mseq;
  logic [31:0] mdrops;
  int          compared;
  int          mismatched;
  logic [31:0] pcv;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic driveRec(input int port, input logic v, input logic t,
                          input logic [31:0] pc, input logic [31:0] cause);
    rvfi_in[port]          = '0;
    rvfi_in[port].valid    = v;
    rvfi_in[port].trap     = t;
    rvfi_in[port].pc_rdata = pc;
    rvfi_in[port].pc_wdata = pc + 32'd4;
    rvfi_in[port].insn     = pc ^ 32'h0000_0013;
    rvfi_in[port].cause    = cause;
  endtask

  // Idle ports still carry junk PCs; they must be ignored.
  task automatic idle();
    driveRec(0, 1'b0, 1'b0, 32'hDEAD_0000, 32'd0);
    driveRec(1, 1'b0, 1'b0, 32'hDEAD_0004, 32'd0);
  endtask

  // One clock cycle: compare DUT outputs against the model, then advance the
  // model with this cycle's pop and push, then step to the next negedge.
  task automatic applyStimulus(input logic rdy);
    exp_t e;
    int   free_slots;
    out_ready = rdy;
    #1;
    checkOutput("level", 64'(level), 64'(sb.size()));
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(mdrops));
    checkOutput("overflow", 64'(overflow), 64'(mdrops != 0));
    if (sb.size() != 0) begin
      e = sb[0];
      checkOutput("valid", 64'(out_valid), 64'd1);
      checkOutput("head_pc", 64'(rvfi_out.pc_rdata), 64'(e.pc));
      checkOutput("head_seq", seq_out, e.seq);
      checkOutput("head_trap", 64'(rvfi_out.trap), 64'(e.trap));
      checkOutput("head_cause", 64'(rvfi_out.cause), 64'(e.cause));
      if (rdy) void'(sb.pop_front());
    end else begin
      checkOutput("valid_empty", 64'(out_valid), 64'd0);
      checkOutput("pc_empty", 64'(rvfi_out.pc_rdata), 64'd0);
      checkOutput("seq_empty", seq_out, 64'd0);
    end
    free_slots = DEPTH - sb.size();
    for (int i = 0; i < NR; i++) begin
      if (rvfi_in[i].valid || rvfi_in[i].trap) begin
        e.pc    = rvfi_in[i].pc_rdata;
        e.seq   = mseq;
        e.trap  = rvfi_in[i].trap;
        e.cause = rvfi_in[i].cause;
        mseq    = mseq + 64'd1;
        if (free_slots > 0) begin
          sb.push_back(e);
          free_slots--;
        end else if (mdrops != 32'hFFFF_FFFF) begin
          mdrops = mdrops + 32'd1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset takes effect asynchronously, so outputs are checked right after
  // rst rises, before any clock edge.
  task automatic doReset();
    idle();
    rst = 1'b1;
    #1;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_seq", seq_out, 64'd0);
    checkOutput("rst_pc", 64'(rvfi_out.pc_rdata), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    sb.delete();
    mseq   = '0;
    mdrops = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    mseq       = '0;
    mdrops     = '0;
    out_ready  = 1'b0;
    rvfi_in    = '0;
    @(negedge clk);
    @(negedge clk);
    doReset();

    // Single port-0 record, consumer always ready.
    repeat (2) applyStimulus(1'b1);
    driveRec(0, 1'b1, 1'b0, 32'h8000_0000, 32'd0);
    driveRec(1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0);
    applyStimulus(1'b1);
    idle();
    repeat (2) applyStimulus(1'b1);

    // Two records in one cycle come out oldest first.
    doReset();
    driveRec(0, 1'b1, 1'b0, 32'h0000_0100, 32'd0);
    driveRec(1, 1'b1, 1'b0, 32'h0000_0104, 32'd0);
    applyStimulus(1'b1);
    idle();
    repeat (3) applyStimulus(1'b1);

    // Trap on port 1 with port 0 idle.
    doReset();
    driveRec(0, 1'b0, 1'b0, 32'h0000_5555, 32'd0);
    driveRec(1, 1'b0, 1'b1, 32'h0000_0200, 32'd2);
    applyStimulus(1'b1);
    idle();
    repeat (2) applyStimulus(1'b1);

    // Overflow with a stalled consumer: 10 records into 8 slots.
    doReset();
    pcv = 32'h0000_1000;
    repeat (5) begin
      driveRec(0, 1'b1, 1'b0, pcv, 32'd0);
      driveRec(1, 1'b1, 1'b0, pcv + 32'd4, 32'd0);
      pcv = pcv + 32'd8;
      applyStimulus(1'b0);
    end
    idle();
    #1;
    checkOutput("ovf_level", 64'(level), 64'd8);
    checkOutput("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    repeat (DEPTH) applyStimulus(1'b1);
    driveRec(0, 1'b1, 1'b0, 32'h0000_2000, 32'd0);
    applyStimulus(1'b1);
    idle();
    #1;
    checkOutput("seq_after_ovf", seq_out, 64'd10);
    applyStimulus(1'b1);

    // Full FIFO with simultaneous pop and two pushes per cycle.
    doReset();
    pcv = 32'h0000_3000;
    repeat (4) begin
      driveRec(0, 1'b1, 1'b0, pcv, 32'd0);
      driveRec(1, 1'b1, 1'b0, pcv + 32'd4, 32'd0);
      pcv = pcv + 32'd8;
      applyStimulus(1'b0);
    end
    repeat (4) begin
      driveRec(0, 1'b1, 1'b0, pcv, 32'd0);
      driveRec(1, 1'b1, 1'b0, pcv + 32'd4, 32'd0);
      pcv = pcv + 32'd8;
      applyStimulus(1'b1);
      #1;
      checkOutput("full_level", 64'(level), 64'd8);
    end
    doReset();
    driveRec(0, 1'b1, 1'b0, 32'h0000_4000, 32'd0);
    applyStimulus(1'b1);
    idle();
    #1;
    checkOutput("seq_after_rst", seq_out, 64'd0);
    applyStimulus(1'b1);

    // Random traffic with random backpressure.
    repeat (80) begin
      for (int p = 0; p < NR; p++) begin
        driveRec(p, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0),
                 $urandom(), 32'($urandom_range(0, 15)));
      end
      applyStimulus(1'($urandom_range(0, 1)));
    end
    idle();
    repeat (DEPTH + 2) applyStimulus(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
